pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit five-stage core. It drives the global `state` line consumed by IF/ID/EX/MEM/WB, detects the one load-use case that the ID forwarding network cannot cover (LOAD in EX feeding the instruction in ID), and generates stall, flush and PC-hold controls. It also handles the run/pause handshake and HALT draining, and keeps cycle and stall counters for bring-up.

---
 rtl/pipe_ctrl_if.sv | 27 ++
 rtl/pipe_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath and its sequencing controller.
// enable is a level permission; start is a one-cycle request taken on the rising edge only while enable is high.
interface pipe_ctrl_if;
    logic        enable;
    logic        start;
    logic [15:0] id_ir;
    logic [15:0] ex_ir;
    logic        jump;
    logic        state;
    logic        stall;
    logic        flush;
    logic        pc_hold;
    logic        halted;
    logic [15:0] cycle_cnt;
    logic [15:0] stall_cnt;
    logic [1:0]  fsm;

    modport master (
        output enable, start, id_ir, ex_ir, jump,
        input  state, stall, flush, pc_hold, halted, cycle_cnt, stall_cnt, fsm
    );

    modport slave (
        input  enable, start, id_ir, ex_ir, jump,
        output state, stall, flush, pc_hold, halted, cycle_cnt, stall_cnt, fsm
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: run/pause/halt FSM, load-use stall detection,
// jump flush, HALT drain and saturating bring-up counters.
module pipe_ctrl (
    input logic        clock,
    input logic        reset,
    pipe_ctrl_if.slave bus
);
    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    localparam logic EXEC = 1'b1;
    localparam logic IDLE = 1'b0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] cycle_q, stall_q;
    logic [4:0]  id_op;
    logic [2:0]  dst;
    logic        use_a, use_b, use_c;
    logic        hz, stall, flush, exec_now;
    logic        unused_bits;

    assign id_op       = bus.id_ir[15:11];
    assign dst         = bus.ex_ir[10:8];
    assign unused_bits = ^{bus.ex_ir[7:0], bus.id_ir[7], bus.id_ir[3]};

    // Which source fields of the ID instruction are real register reads.
    always_comb begin
        use_a = 1'b0;
        use_b = 1'b0;
        use_c = 1'b0;
        case (id_op)
            OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC,
            OP_JMPR, OP_ADDI, OP_SUBI, OP_LDIH: use_a = 1'b1;
            OP_STORE: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA: use_b = 1'b1;
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
            OP_CMP, OP_AND, OP_OR, OP_XOR: begin
                use_b = 1'b1;
                use_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign hz = (bus.ex_ir[15:11] == OP_LOAD) &&
                ((use_a && (bus.id_ir[10:8] == dst)) ||
                 (use_b && (bus.id_ir[6:4]  == dst)) ||
                 (use_c && (bus.id_ir[2:0]  == dst)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q   <= S_IDLE;
            drain_q <= 2'd0;
        end else begin
            fsm_q   <= fsm_d;
            drain_q <= drain_d;
        end
    end

    // A taken jump squashes ID, so a HALT sitting there must not start the drain.
    always_comb begin
        fsm_d   = fsm_q;
        drain_d = drain_q;
        stall   = 1'b0;
        flush   = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (bus.start && bus.enable) fsm_d = S_RUN;
            end
            S_RUN: begin
                stall = hz && !bus.jump;
                flush = bus.jump;
                if (!bus.enable) begin
                    fsm_d = S_IDLE;
                end else if ((id_op == OP_HALT) && !bus.jump && !stall) begin
                    fsm_d   = S_DRAIN;
                    drain_d = 2'd3;
                end
            end
            S_DRAIN: begin
                flush   = bus.jump;
                drain_d = drain_q - 2'd1;
                if (drain_q <= 2'd1) fsm_d = S_HALTED;
            end
            S_HALTED: ;
            default: fsm_d = S_IDLE;
        endcase
    end

    assign exec_now = (fsm_q == S_RUN) || (fsm_q == S_DRAIN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q <= 16'd0;
            stall_q <= 16'd0;
        end else begin
            if (exec_now && (cycle_q != 16'hFFFF)) cycle_q <= cycle_q + 16'd1;
            if (stall && (stall_q != 16'hFFFF))    stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.state     = exec_now ? EXEC : IDLE;
    assign bus.stall     = stall;
    assign bus.flush     = flush;
    assign bus.pc_hold   = (fsm_q == S_DRAIN);
    assign bus.halted    = (fsm_q == S_HALTED);
    assign bus.cycle_cnt = cycle_q;
    assign bus.stall_cnt = stall_q;
    assign bus.fsm       = fsm_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a reference model feeds an expected-output queue checked every cycle,
// plus directed checks of load-use stalls, pause/resume, HALT drain, async reset and saturation.
module tb_pipe_ctrl;
    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    localparam logic [15:0] I_NOP    = 16'h0000;
    localparam logic [15:0] LD3      = {OP_LOAD, 3'd3, 1'b0, 3'd2, 4'd1};
    localparam logic [15:0] ADD_HZ   = {OP_ADD, 3'd1, 1'b0, 3'd4, 1'b0, 3'd3};
    localparam logic [15:0] ADD_NOHZ = {OP_ADD, 3'd1, 1'b0, 3'd4, 1'b0, 3'd5};
    localparam logic [15:0] LD2      = {OP_LOAD, 3'd2, 1'b0, 3'd0, 4'd0};
    localparam logic [15:0] LD6      = {OP_LOAD, 3'd6, 1'b0, 3'd1, 4'd0};
    localparam logic [15:0] LD0      = {OP_LOAD, 3'd0, 1'b0, 3'd1, 4'd0};
    localparam logic [15:0] ST2      = {OP_STORE, 3'd2, 1'b0, 3'd6, 4'd0};
    localparam logic [15:0] I_HALT   = {OP_HALT, 11'd0};
    localparam logic [15:0] I_JUMP   = {OP_JUMP, 11'd0};

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipe_ctrl_if bus();

    pipe_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [36:0] exp_q[$];
    int          m_fsm;
    int          m_drain;
    logic [15:0] m_cyc;
    logic [15:0] m_stl;
    wire  [36:0] outs = {bus.state, bus.stall, bus.flush, bus.pc_hold, bus.halted,
                         bus.cycle_cnt, bus.stall_cnt};

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ref_hz(input logic [15:0] id, input logic [15:0] ex);
        logic [4:0] o;
        logic [2:0] d;
        o = id[15:11];
        d = ex[10:8];
        if (ex[15:11] != OP_LOAD) return 1'b0;
        if ((o inside {OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR,
                       OP_ADDI, OP_SUBI, OP_LDIH, OP_STORE}) && (id[10:8] == d)) return 1'b1;
        if ((o inside {OP_LOAD, OP_STORE, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
                       OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA}) &&
            (id[6:4] == d)) return 1'b1;
        if ((o inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR}) &&
            (id[2:0] == d)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [36:0] model_outs();
        logic run, drn, st, stl, fl;
        run = (m_fsm == 1);
        drn = (m_fsm == 2);
        st  = run || drn;
        stl = run && ref_hz(bus.id_ir, bus.ex_ir) && !bus.jump;
        fl  = bus.jump && st;
        return {st, stl, fl, drn, (m_fsm == 3), m_cyc, m_stl};
    endfunction

    task automatic model_reset();
        m_fsm   = 0;
        m_drain = 0;
        m_cyc   = 16'd0;
        m_stl   = 16'd0;
    endtask

    task automatic model_step();
        logic [36:0] o;
        if (!reset) begin
            model_reset();
            return;
        end
        o = model_outs();
        if (o[36] && m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
        if (o[35] && m_stl != 16'hFFFF) m_stl = m_stl + 16'd1;
        case (m_fsm)
            0: if (bus.start && bus.enable) m_fsm = 1;
            1: begin
                if (!bus.enable) m_fsm = 0;
                else if (bus.id_ir[15:11] == OP_HALT && !bus.jump && !o[35]) begin
                    m_fsm   = 2;
                    m_drain = 3;
                end
            end
            2: begin
                m_drain = m_drain - 1;
                if (m_drain == 0) m_fsm = 3;
            end
            default: ;
        endcase
    endtask

    // Push what this cycle should show, compare mid-cycle, then advance one edge.
    task automatic tick();
        exp_q.push_back(model_outs());
        @(negedge clock);
        check("cycle", outs, exp_q.pop_front());
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_outs", outs, 37'd0);
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        bus.ex_ir = I_NOP;
        bus.id_ir = I_NOP;
        bus.jump  = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic run_start();
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        bus.id_ir  = I_NOP;
        bus.ex_ir  = I_NOP;
        bus.jump   = 1'b0;
        model_reset();
        #1;
        check("rst_init", outs, 37'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // start without enable is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("start_no_en", bus.state, 1'b0);

        run_start();
        check("start_exec", bus.state, 1'b1);
        check("cyc_zero", bus.cycle_cnt, 16'd0);
        tick();
        check("cyc_first", bus.cycle_cnt, 16'd1);

        // load-use through [2:0]
        bus.ex_ir = LD3;
        bus.id_ir = ADD_HZ;
        #1 check("hz_add", bus.stall, 1'b1);
        tick();
        bus.ex_ir = I_NOP;
        #1 check("hz_clear", bus.stall, 1'b0);
        check("stall_cnt1", bus.stall_cnt, 16'd1);
        bus.ex_ir = LD3;
        bus.id_ir = ADD_NOHZ;
        #1 check("nohz_add", bus.stall, 1'b0);
        tick();

        // [10:8] field via STORE, then jump overrides
        bus.ex_ir = LD2;
        bus.id_ir = ST2;
        #1 check("hz_store", bus.stall, 1'b1);
        bus.jump = 1'b1;
        #1 check("jump_nostall", bus.stall, 1'b0);
        check("jump_flush", bus.flush, 1'b1);
        tick();
        bus.jump = 1'b0;
        check("stall_cnt_jmp", bus.stall_cnt, 16'd1);

        // [6:4] field via STORE base
        bus.ex_ir = LD6;
        #1 check("hz_base", bus.stall, 1'b1);
        tick();
        bus.ex_ir = LD0;
        bus.id_ir = I_NOP;
        #1 check("nop_nohz", bus.stall, 1'b0);
        bus.id_ir = I_JUMP;
        #1 check("jump_nohz", bus.stall, 1'b0);

        // pause while a stall is pending: stall still counts
        bus.enable = 1'b0;
        bus.ex_ir  = LD3;
        bus.id_ir  = ADD_HZ;
        #1 check("pause_stall", bus.stall, 1'b1);
        tick();
        bus.ex_ir = I_NOP;
        check("pause_idle", bus.state, 1'b0);
        check("stall_cnt3", bus.stall_cnt, 16'd3);
        check("cyc_pause", bus.cycle_cnt, 16'd6);
        repeat (3) tick();
        bus.enable = 1'b1;
        tick();
        check("en_no_start", bus.state, 1'b0);
        check("cyc_frozen", bus.cycle_cnt, 16'd6);
        run_start();
        check("resume", bus.state, 1'b1);
        check("cyc_resume", bus.cycle_cnt, 16'd6);

        // HALT under a taken jump is squashed
        bus.id_ir = I_HALT;
        bus.jump  = 1'b1;
        #1 check("halt_jmp_flush", bus.flush, 1'b1);
        tick();
        bus.jump = 1'b0;
        bus.id_ir = I_NOP;
        check("halt_jmp_nodrain", bus.pc_hold, 1'b0);
        check("halt_jmp_exec", bus.state, 1'b1);

        // HALT drain
        bus.id_ir = I_HALT;
        tick();
        bus.id_ir = I_NOP;
        check("drain1", {bus.state, bus.pc_hold, bus.halted}, 3'b110);
        tick();
        check("drain2", bus.pc_hold, 1'b1);
        bus.jump = 1'b1;
        #1 check("drain_flush", bus.flush, 1'b1);
        tick();
        bus.jump = 1'b0;
        check("drain3", {bus.pc_hold, bus.halted}, 2'b10);
        tick();
        check("halted", {bus.state, bus.pc_hold, bus.halted}, 3'b001);
        check("cyc_halt", bus.cycle_cnt, 16'd11);
        run_start();
        tick();
        check("halt_sticky", bus.halted, 1'b1);
        check("cyc_halt_hold", bus.cycle_cnt, 16'd11);

        // async reset mid-DRAIN
        do_reset();
        run_start();
        bus.id_ir = I_HALT;
        tick();
        bus.id_ir = I_NOP;
        check("drain_again", bus.pc_hold, 1'b1);
        reset = 1'b0;
        #1 check("rst_mid_drain", outs, 37'd0);
        model_reset();
        repeat (2) tick();
        reset = 1'b1;

        // async reset mid-stall
        run_start();
        bus.ex_ir = LD3;
        bus.id_ir = ADD_HZ;
        #1 check("stall_pre_rst", bus.stall, 1'b1);
        reset = 1'b0;
        #1 check("rst_mid_stall", outs, 37'd0);
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        bus.ex_ir = I_NOP;
        bus.id_ir = I_NOP;

        // saturation
        run_start();
        for (int i = 0; i < 65540; i++) tick();
        check("cyc_sat", bus.cycle_cnt, 16'hFFFF);
        tick();
        check("cyc_sat_hold", bus.cycle_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
